uart_io_port: RTL and testbench
===============================

# uart_io_port

CPU-facing I/O port decoder sitting directly upstream of `uart_controller`. It maps three I/O addresses onto the controller:

- Transmit/receive data.
- Status.
- Interrupt control.

It turns CPU read/write strobes into the controller's `wr_en`/`data` write pulse and an RX-FIFO pop. It returns read data with a ready handshake and raises a level interrupt from the controller status.

## Interface
Parameters:
- `BASE_ADDR`, default 8'h10: base I/O address. DATA = BASE, STATUS = BASE+1, CTRL = BASE+2.

Ports:
- `clk`  in  1  system clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-low reset (rst==0 resets on the clock edge).
- `io_addr`  in  8  I/O address, sampled with a strobe.
- `io_wdata`  in  16  write data.
- `io_wr`  in  1  write strobe.
- `io_rd`  in  1  read strobe.
- `io_rdata`  out  16  read data; holds until the next read completes.
- `io_ready`  out  1  one-cycle pulse: transaction complete.
- `irq`  out  1  registered interrupt level.
- `uart_wr_en`  out  1  one-cycle TX push to the controller.
- `uart_data`  out  16  TX data to the controller (bits 7:0 used).
- `uart_rx_pop`  out  1  one-cycle RX-FIFO pop.
- `uart_rx_data`  in  8  RX-FIFO head; valid 2 cycles after a pop.
- `uart_status`  in  8  controller status: bit0 tx not full, bit1 tx empty, bit2 rx not empty.

## Operation
- FSM states: IDLE, WSET, RPOP, RWAIT, RDONE.
- Strobes are sampled only in IDLE; strobes in any other state are ignored. The host waits for `io_ready`.
- If `io_wr` and `io_rd` are both high, the write is taken and the read is dropped.
- Write to DATA with status bit0 = 1:
  - Pulse `uart_wr_en`; drive `uart_data` = `io_wdata`.
  - Go to WSET for 2 cycles so the lagging controller status settles, then IDLE.
- Write to DATA with status bit0 = 0 (TX full):
  - No push; set sticky `ovf`.
  - Acknowledge, and still pass through WSET.
- Write to STATUS: W1C. `io_wdata[4]` clears `ovf`; `io_wdata[5]` clears `udf`.
- Write to CTRL: `io_wdata[0]` = `rx_ie`, `io_wdata[1]` = `tx_ie`.
- Read of STATUS returns {6'b0, `tx_ie`, `rx_ie`, 2'b0, `udf`, `ovf`, `uart_status[3:0]`}.
- Read of CTRL returns {14'b0, `tx_ie`, `rx_ie`}.
- Read of DATA with status bit2 = 1: RPOP (pulse `uart_rx_pop`), then RWAIT, then RDONE. RDONE captures {8'h00, `uart_rx_data`}.
- Read of DATA with status bit2 = 0: no pop; return 16'h8000 and set `udf`.
- Unmapped address: writes are acknowledged and have no effect; reads return 16'h0000.
- `irq` <= (`rx_ie` & `uart_status[2]`) | (`tx_ie` & `uart_status[1]`).
- Sticky-flag set and W1C clear in the same cycle: set wins.
- Reset values:
  - State IDLE.
  - `io_rdata` = 0; `io_ready`, `irq`, `uart_wr_en`, `uart_rx_pop` = 0; `uart_data` = 0.
  - `ovf`, `udf`, `rx_ie`, `tx_ie` = 0.
- Reset mid-transaction aborts it: no `io_ready`, and no pending pop or push is issued.

## Timing
- Strobe sampled at edge 0.
- DATA write: `uart_wr_en` and `io_ready` high in cycle 1. WSET covers cycles 1–2. IDLE again at cycle 3, so the earliest next accepted strobe is cycle 3.
- CTRL/STATUS/unmapped access, or any 1-cycle read: `io_ready` and `io_rdata` valid in cycle 1; back in IDLE at cycle 1.
- DATA read, non-empty: `uart_rx_pop` in cycle 1, RWAIT in cycle 2, `io_rdata` valid with `io_ready` in cycle 3, IDLE at cycle 4.
- DATA read, empty: 16'h8000 with `io_ready` in cycle 1.
- `irq` follows `uart_status` and the enables with 1 cycle of latency.
- `uart_status` is sampled in the cycle of the strobe (IDLE).

## Structure
- Shared package `uart_io_pkg` holds:
  - Address offsets DATA = 0, STATUS = 1, CTRL = 2.
  - FSM state encoding.
  - Status/ctrl bit positions: OVF = 4, UDF = 5, RX_IE = 0, TX_IE = 1.
  - The empty-read code 16'h8000.
- Single module, no sub-module. The FSM, decode, sticky flags and irq register all live in one block of roughly 150–250 lines.

## Test plan
- Reset with rst = 0 for 2 cycles → all outputs 0; reading STATUS with `uart_status` = 8'h03 returns 16'h0003.
- Write DATA = 16'h0041 with status bit0 = 1 → `uart_wr_en` = 1 and `uart_data` = 16'h0041 in cycle 1, `io_ready` in cycle 1; an `io_wr` in cycle 2 is ignored.
- Write DATA with status bit0 = 0 → no `uart_wr_en`; STATUS read shows bit4 = 1; writing STATUS 16'h0010 clears it.
- Read DATA with status bit2 = 1 and `uart_rx_data` = 8'h5A → `uart_rx_pop` in cycle 1; `io_rdata` = 16'h005A with `io_ready` in cycle 3.
- Read DATA with RX empty → `io_rdata` = 16'h8000 in cycle 1, no pop, `udf` = 1.
- Write CTRL = 16'h0001, then raise `uart_status[2]` → `irq` = 1 one cycle later. Assert rst = 0 during RWAIT → no `io_ready`, `irq` = 0, state IDLE.

Source files
------------

// File: rtl/uart_io_pkg.sv
// Shared definitions for the uart_io_port CPU I/O decoder.
// Provides the register offsets from BASE_ADDR, the FSM state encoding,
// the status/ctrl bit positions, and the empty-read code.
package uart_io_pkg;

    // Register offsets from BASE_ADDR
    localparam logic [7:0] OFF_DATA   = 8'd0;
    localparam logic [7:0] OFF_STATUS = 8'd1;
    localparam logic [7:0] OFF_CTRL   = 8'd2;

    // Bit positions in the STATUS word (sticky flags) and the CTRL word (enables)
    localparam int BIT_OVF   = 4;
    localparam int BIT_UDF   = 5;
    localparam int BIT_RX_IE = 0;
    localparam int BIT_TX_IE = 1;

    // Value returned by a DATA read while the RX FIFO is empty
    localparam logic [15:0] RD_EMPTY = 16'h8000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WSET  = 3'd1,
        RPOP  = 3'd2,
        RWAIT = 3'd3,
        RDONE = 3'd4
    } io_state_e;

endpackage

// File: rtl/uart_io_port.sv
// uart_io_port: CPU-facing I/O decoder in front of uart_controller.
// Ports:
//   clk, rst            - clock; synchronous active-low reset
//   io_addr/io_wdata    - CPU address and write data, sampled with a strobe
//   io_wr/io_rd         - CPU strobes, accepted only in IDLE (write wins)
//   io_rdata/io_ready   - read data (held) and one-cycle completion pulse
//   irq                 - registered interrupt level
//   uart_wr_en/uart_data- one-cycle TX push and its data
//   uart_rx_pop         - one-cycle RX-FIFO pop
//   uart_rx_data        - RX-FIFO head, valid two cycles after a pop
//   uart_status         - bit0 tx not full, bit1 tx empty, bit2 rx not empty
module uart_io_port
    import uart_io_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'h10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  io_addr,
    input  logic [15:0] io_wdata,
    input  logic        io_wr,
    input  logic        io_rd,
    output logic [15:0] io_rdata,
    output logic        io_ready,
    output logic        irq,
    output logic        uart_wr_en,
    output logic [15:0] uart_data,
    output logic        uart_rx_pop,
    input  logic [7:0]  uart_rx_data,
    input  logic [7:0]  uart_status
);

    localparam logic [7:0] A_DATA   = BASE_ADDR + OFF_DATA;
    localparam logic [7:0] A_STATUS = BASE_ADDR + OFF_STATUS;
    localparam logic [7:0] A_CTRL   = BASE_ADDR + OFF_CTRL;

    io_state_e   state_q, state_d;
    logic        wcnt_q, wcnt_d;
    logic [15:0] io_rdata_q, io_rdata_d;
    logic        io_ready_q, io_ready_d;
    logic        irq_q, irq_d;
    logic        uart_wr_en_q, uart_wr_en_d;
    logic [15:0] uart_data_q, uart_data_d;
    logic        uart_rx_pop_q, uart_rx_pop_d;
    logic        ovf_q, ovf_d, udf_q, udf_d;
    logic        rx_ie_q, rx_ie_d, tx_ie_q, tx_ie_d;
    logic        ovf_set, ovf_clr, udf_set, udf_clr;
    logic [15:0] status_word, ctrl_word;

    always_comb begin
        status_word = 16'h0000;
        status_word[3:0]              = uart_status[3:0];
        status_word[BIT_OVF]          = ovf_q;
        status_word[BIT_UDF]          = udf_q;
        status_word[8 + BIT_RX_IE]    = rx_ie_q;
        status_word[8 + BIT_TX_IE]    = tx_ie_q;
        ctrl_word = 16'h0000;
        ctrl_word[BIT_RX_IE] = rx_ie_q;
        ctrl_word[BIT_TX_IE] = tx_ie_q;
    end

    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        io_rdata_d    = io_rdata_q;
        io_ready_d    = 1'b0;
        uart_wr_en_d  = 1'b0;
        uart_data_d   = uart_data_q;
        uart_rx_pop_d = 1'b0;
        rx_ie_d       = rx_ie_q;
        tx_ie_d       = tx_ie_q;
        ovf_set       = 1'b0;
        ovf_clr       = 1'b0;
        udf_set       = 1'b0;
        udf_clr       = 1'b0;

        case (state_q)
            IDLE: begin
                if (io_wr) begin
                    io_ready_d = 1'b1;
                    case (io_addr)
                        A_DATA: begin
                            if (uart_status[0]) begin
                                uart_wr_en_d = 1'b1;
                                uart_data_d  = io_wdata;
                            end else begin
                                ovf_set = 1'b1;
                            end
                            // Give the controller's status two cycles to reflect the push
                            state_d = WSET;
                            wcnt_d  = 1'b0;
                        end
                        A_STATUS: begin
                            ovf_clr = io_wdata[BIT_OVF];
                            udf_clr = io_wdata[BIT_UDF];
                        end
                        A_CTRL: begin
                            rx_ie_d = io_wdata[BIT_RX_IE];
                            tx_ie_d = io_wdata[BIT_TX_IE];
                        end
                        default: ;
                    endcase
                end else if (io_rd) begin
                    case (io_addr)
                        A_DATA: begin
                            if (uart_status[2]) begin
                                uart_rx_pop_d = 1'b1;
                                state_d       = RPOP;
                            end else begin
                                io_ready_d = 1'b1;
                                io_rdata_d = RD_EMPTY;
                                udf_set    = 1'b1;
                            end
                        end
                        A_STATUS: begin
                            io_ready_d = 1'b1;
                            io_rdata_d = status_word;
                        end
                        A_CTRL: begin
                            io_ready_d = 1'b1;
                            io_rdata_d = ctrl_word;
                        end
                        default: begin
                            io_ready_d = 1'b1;
                            io_rdata_d = 16'h0000;
                        end
                    endcase
                end
            end
            WSET: begin
                if (wcnt_q) state_d = IDLE;
                else        wcnt_d  = 1'b1;
            end
            RPOP:  state_d = RWAIT;
            RWAIT: begin
                // Capture on entry to RDONE so data and ready are visible during RDONE
                state_d    = RDONE;
                io_ready_d = 1'b1;
                io_rdata_d = {8'h00, uart_rx_data};
            end
            RDONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Set beats a same-cycle W1C clear
        ovf_d = (ovf_q & ~ovf_clr) | ovf_set;
        udf_d = (udf_q & ~udf_clr) | udf_set;
        irq_d = (rx_ie_q & uart_status[2]) | (tx_ie_q & uart_status[1]);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            wcnt_q        <= 1'b0;
            io_rdata_q    <= 16'h0000;
            io_ready_q    <= 1'b0;
            irq_q         <= 1'b0;
            uart_wr_en_q  <= 1'b0;
            uart_data_q   <= 16'h0000;
            uart_rx_pop_q <= 1'b0;
            ovf_q         <= 1'b0;
            udf_q         <= 1'b0;
            rx_ie_q       <= 1'b0;
            tx_ie_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            io_rdata_q    <= io_rdata_d;
            io_ready_q    <= io_ready_d;
            irq_q         <= irq_d;
            uart_wr_en_q  <= uart_wr_en_d;
            uart_data_q   <= uart_data_d;
            uart_rx_pop_q <= uart_rx_pop_d;
            ovf_q         <= ovf_d;
            udf_q         <= udf_d;
            rx_ie_q       <= rx_ie_d;
            tx_ie_q       <= tx_ie_d;
        end
    end

    assign io_rdata    = io_rdata_q;
    assign io_ready    = io_ready_q;
    assign irq         = irq_q;
    assign uart_wr_en  = uart_wr_en_q;
    assign uart_data   = uart_data_q;
    assign uart_rx_pop = uart_rx_pop_q;

endmodule

// File: tb/tb_uart_io_port.sv
// Directed bench for uart_io_port. Inputs change 1ns after a rising edge,
// outputs are checked at the same point, so "cycle N" below means the
// cycle following the N-th edge after the strobe was presented.
module tb_uart_io_port;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  io_addr;
    logic [15:0] io_wdata;
    logic        io_wr, io_rd;
    logic [15:0] io_rdata;
    logic        io_ready, irq, uart_wr_en, uart_rx_pop;
    logic [15:0] uart_data;
    logic [7:0]  uart_rx_data, uart_status;

    int n_pass  = 0;
    int n_total = 0;

    uart_io_port #(.BASE_ADDR(8'h10)) dut (
        .clk          (clk),
        .rst          (rst),
        .io_addr      (io_addr),
        .io_wdata     (io_wdata),
        .io_wr        (io_wr),
        .io_rd        (io_rd),
        .io_rdata     (io_rdata),
        .io_ready     (io_ready),
        .irq          (irq),
        .uart_wr_en   (uart_wr_en),
        .uart_data    (uart_data),
        .uart_rx_pop  (uart_rx_pop),
        .uart_rx_data (uart_rx_data),
        .uart_status  (uart_status)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b0; io_addr = 8'h00; io_wdata = 16'h0000; io_wr = 1'b0; io_rd = 1'b0;
        uart_rx_data = 8'h00; uart_status = 8'h00;
        tick(); tick();
        chk("rst_rdata", io_rdata, 16'h0000);
        chk("rst_ready", io_ready, 16'h0);
        chk("rst_irq",   irq, 16'h0);
        chk("rst_wr_en", uart_wr_en, 16'h0);
        chk("rst_data",  uart_data, 16'h0000);
        chk("rst_pop",   uart_rx_pop, 16'h0);
        rst = 1'b1;
        tick();

        // STATUS read after reset
        uart_status = 8'h03; io_addr = 8'h11; io_rd = 1'b1;
        tick(); io_rd = 1'b0;
        chk("st0_ready", io_ready, 16'h1);
        chk("st0_rdata", io_rdata, 16'h0003);
        tick();
        chk("st0_ready_drop", io_ready, 16'h0);

        // DATA write with room; a second write during WSET is ignored
        io_addr = 8'h10; io_wdata = 16'h0041; io_wr = 1'b1;
        tick(); io_wr = 1'b0;
        chk("wr_en_c1",  uart_wr_en, 16'h1);
        chk("wr_data_c1", uart_data, 16'h0041);
        chk("wr_rdy_c1", io_ready, 16'h1);
        tick();
        io_wdata = 16'h0042; io_wr = 1'b1;
        tick(); io_wr = 1'b0;
        chk("wset_ign_en",  uart_wr_en, 16'h0);
        chk("wset_ign_rdy", io_ready, 16'h0);
        tick();
        chk("wset_ign_data", uart_data, 16'h0041);
        chk("wset_ign_en2",  uart_wr_en, 16'h0);

        // DATA write with TX full -> ovf
        uart_status = 8'h02; io_wdata = 16'h0055; io_wr = 1'b1;
        tick(); io_wr = 1'b0;
        chk("ovf_no_push", uart_wr_en, 16'h0);
        chk("ovf_ack",     io_ready, 16'h1);
        chk("ovf_data",    uart_data, 16'h0041);
        tick(); tick();
        io_addr = 8'h11; io_rd = 1'b1;
        tick(); io_rd = 1'b0;
        chk("ovf_status", io_rdata, 16'h0012);
        io_wdata = 16'h0010; io_wr = 1'b1;
        tick(); io_wr = 1'b0;
        chk("w1c_ack", io_ready, 16'h1);
        io_rd = 1'b1;
        tick(); io_rd = 1'b0;
        chk("ovf_cleared", io_rdata, 16'h0002);

        // DATA read, RX not empty
        uart_status = 8'h04; uart_rx_data = 8'h5A; io_addr = 8'h10; io_rd = 1'b1;
        tick(); io_rd = 1'b0;
        chk("rd_pop_c1", uart_rx_pop, 16'h1);
        chk("rd_rdy_c1", io_ready, 16'h0);
        tick();
        chk("rd_pop_c2", uart_rx_pop, 16'h0);
        chk("rd_rdy_c2", io_ready, 16'h0);
        tick();
        chk("rd_rdy_c3",   io_ready, 16'h1);
        chk("rd_rdata_c3", io_rdata, 16'h005A);
        tick();
        chk("rd_rdy_c4",  io_ready, 16'h0);
        chk("rd_hold_c4", io_rdata, 16'h005A);

        // DATA read, RX empty -> 8000 and udf
        uart_status = 8'h00; io_rd = 1'b1;
        tick(); io_rd = 1'b0;
        chk("udf_rdata", io_rdata, 16'h8000);
        chk("udf_rdy",   io_ready, 16'h1);
        chk("udf_nopop", uart_rx_pop, 16'h0);
        io_addr = 8'h11; io_rd = 1'b1;
        tick(); io_rd = 1'b0;
        chk("udf_status", io_rdata, 16'h0020);
        io_wdata = 16'h0020; io_wr = 1'b1;
        tick(); io_wr = 1'b0;
        io_rd = 1'b1;
        tick(); io_rd = 1'b0;
        chk("udf_cleared", io_rdata, 16'h0000);

        // Unmapped read and write
        io_addr = 8'h20; io_rd = 1'b1;
        tick(); io_rd = 1'b0;
        chk("unmap_rd_rdy", io_ready, 16'h1);
        chk("unmap_rdata",  io_rdata, 16'h0000);
        io_wdata = 16'hFFFF; io_wr = 1'b1;
        tick(); io_wr = 1'b0;
        chk("unmap_wr_rdy", io_ready, 16'h1);
        chk("unmap_wr_en",  uart_wr_en, 16'h0);

        // rx_ie and irq
        io_addr = 8'h12; io_wdata = 16'h0001; io_wr = 1'b1;
        tick(); io_wr = 1'b0;
        chk("ctrl_rdy", io_ready, 16'h1);
        tick();
        chk("irq_low", irq, 16'h0);
        uart_status = 8'h04;
        tick();
        chk("irq_rx", irq, 16'h1);
        io_rd = 1'b1;
        tick(); io_rd = 1'b0;
        chk("ctrl_rd", io_rdata, 16'h0001);

        // tx_ie only: tx empty raises irq, rx not-empty does not
        io_wdata = 16'h0002; io_wr = 1'b1;
        tick(); io_wr = 1'b0;
        tick();
        chk("irq_tx_off", irq, 16'h0);
        uart_status = 8'h02;
        tick();
        chk("irq_tx", irq, 16'h1);
        io_wdata = 16'h0001; io_wr = 1'b1;
        tick(); io_wr = 1'b0;

        // Reset during RWAIT aborts the read
        uart_status = 8'h04; uart_rx_data = 8'h77; io_addr = 8'h10; io_rd = 1'b1;
        tick(); io_rd = 1'b0;
        chk("ab_pop", uart_rx_pop, 16'h1);
        tick();
        chk("ab_irq_pre", irq, 16'h1);
        rst = 1'b0;
        tick();
        chk("ab_rdy",  io_ready, 16'h0);
        chk("ab_irq",  irq, 16'h0);
        chk("ab_pop2", uart_rx_pop, 16'h0);
        rst = 1'b1;
        tick();
        chk("ab_rdy2",  io_ready, 16'h0);
        chk("ab_rdata", io_rdata, 16'h0000);
        // IDLE accepts a strobe right away; enables were cleared
        io_addr = 8'h12; io_rd = 1'b1;
        tick(); io_rd = 1'b0;
        chk("ab_idle_rdy", io_ready, 16'h1);
        chk("ab_ctrl_clr", io_rdata, 16'h0000);
        chk("ab_irq2",     irq, 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
